// File: rtl/reg_dump_rv32i.sv
// Sequential read-out engine for the RV32I register file: walks an address range
// through one read port and streams {addr, data} over valid/ready. Optional macro: REG_DUMP_CHECKSUM_EN.
module reg_dump_rv32i #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rs_addr,
  input  logic [DATA_W-1:0] rs_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] end_addr;
  logic              start_acc;
  logic              hs;
  logic              last_word;

  assign last_word = (out_addr == end_addr);
  // The counter itself is the registered read address; it only moves on READ entry.
  assign rs_addr   = addr_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    hs        = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = READ;
        end
      end
      READ: state_nxt = SEND;
      SEND: begin
        if (out_valid && out_ready) begin
          hs        = 1'b1;
          state_nxt = last_word ? DONE : READ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_cnt  <= '0;
      end_addr  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      if (start_acc) begin
        addr_cnt <= first_addr;
        end_addr <= last_addr;
      end
      if (state == READ) begin
        out_data  <= rs_data;
        out_addr  <= addr_cnt;
        out_valid <= 1'b1;
      end
      // Counter wraps naturally at 2^ADDR_W, giving the 31 -> 0 rollover.
      if (hs) begin
        out_valid <= 1'b0;
        if (!last_word) addr_cnt <= addr_cnt + ADDR_W'(1);
      end
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_acc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       sum_acc <= '0;
    else if (start_acc) sum_acc <= '0;
    else if (hs)        sum_acc <= sum_acc + out_data;
  end

  assign checksum = sum_acc;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_reg_dump_rv32i.sv
// Randomized bench for reg_dump_rv32i with a behavioural register file and an
// expected-stream queue built from the dump range rules.
module tb_reg_dump_rv32i;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  rs_addr;
  logic [31:0] rs_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic [31:0] regs [32];
  int checks = 0;
  int errors = 0;

  reg_dump_rv32i #(.ADDR_W(5), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .rs_addr(rs_addr), .rs_data(rs_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .checksum(checksum)
  );

  assign rs_data = regs[rs_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input int idx, input logic [31:0] val);
    if (idx != 0) regs[idx] = val;
  endtask

  function automatic logic [31:0] exp_checksum(input logic [31:0] s);
`ifdef REG_DUMP_CHECKSUM_EN
    return s;
`else
    return 32'h0 & s;
`endif
  endfunction

  // mode 0: ready held high; 1: random ready; 2: ready low for 5 valid cycles
  task automatic run_dump(input logic [4:0] first, input logic [4:0] last,
                          input int mode, input bit poke_start);
    logic [4:0]  exp_a [$];
    logic [31:0] exp_d [$];
    logic [31:0] sum;
    logic [4:0]  ha;
    logic [31:0] hd;
    bit          holding;
    bit          seen_done;
    bit          seen_valid;
    bit          r;
    int          n;
    int          k;
    n = ((int'(last) - int'(first) + 32) % 32) + 1;
    sum = 32'h0;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(5'((int'(first) + i) % 32));
      exp_d.push_back(regs[(int'(first) + i) % 32]);
      sum = sum + regs[(int'(first) + i) % 32];
    end
    holding = 0; seen_done = 0; seen_valid = 0;
    @(negedge clock);
    first_addr = first; last_addr = last; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 1;
    check_val("busy_after_start", busy, 1);
    while (!seen_done && k < 400) begin
      if (poke_start && k == 3) begin
        start = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen_done = 1;
        check_val("words_left_at_done", exp_a.size(), 0);
        check_val("checksum_at_done", checksum, exp_checksum(sum));
        if (mode == 0) check_val("done_cycle", k, 2 * n + 1);
        if (mode == 2) check_val("done_after_ready", k, 8);
      end else if (out_valid) begin
        if (!seen_valid && mode == 0) check_val("first_valid_cycle", k, 2);
        seen_valid = 1;
        if (holding) begin
          check_val("hold_addr", out_addr, ha);
          check_val("hold_data", out_data, hd);
        end
        case (mode)
          0:       r = 1'b1;
          1:       r = 1'($urandom_range(0, 1));
          default: r = (k > 6);
        endcase
        out_ready = r;
        if (r) begin
          holding = 0;
          if (exp_a.size() == 0) begin
            check_val("extra_word", 1, 0);
          end else begin
            check_val("word_addr", out_addr, exp_a.pop_front());
            check_val("word_data", out_data, exp_d.pop_front());
            check_val("rs_addr_hold", rs_addr, out_addr);
          end
        end else begin
          holding = 1; ha = out_addr; hd = out_data;
        end
      end else begin
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    if (!seen_done) check_val("dump_timeout", 0, 1);
    check_val("done_one_cycle", done, 0);
    check_val("busy_after_done", busy, 0);
    check_val("checksum_stable", checksum, exp_checksum(sum));
  endtask

  task automatic reset_mid_dump();
    int k;
    bit bad_done;
    @(negedge clock);
    first_addr = 5'd0; last_addr = 5'd4; start = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (k = 1; k < 6; k++) @(negedge clock);
    check_val("third_word_valid", out_valid, 1);
    check_val("third_word_addr", out_addr, 2);
    reset_n = 1'b0;
    #1;
    check_val("rst_async_vector",
              {rs_addr, out_valid, out_addr, out_data, busy, done, checksum}, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    bad_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done) bad_done = 1;
    end
    check_val("no_done_after_abort", bad_done, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    first_addr = 5'd0; last_addr = 5'd0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    #12;
    check_val("reset_vector",
              {rs_addr, out_valid, out_addr, out_data, busy, done, checksum}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    write_reg(1, 32'h000000A1);
    write_reg(2, 32'h00000ABC);
    write_reg(3, 32'h12345678);
    write_reg(4, 32'hFFFFFFFF);
    write_reg(0, 32'hC0C0C0C0);

    run_dump(5'd0, 5'd9, 0, 0);
    run_dump(5'd30, 5'd1, 0, 0);
    run_dump(5'd3, 5'd3, 2, 0);
    run_dump(5'd0, 5'd4, 0, 1);
    reset_mid_dump();
    run_dump(5'd2, 5'd2, 0, 0);
    run_dump(5'd0, 5'd31, 0, 0);

    for (int i = 1; i < 32; i++) write_reg(i, $urandom);
    for (int t = 0; t < 8; t++)
      run_dump(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
